// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared register-file constants and types, used by the register file, the
// ALU blocks and the register-file write-port scheduler.
//   REGFILE_ADDR_W   : register address width
//   REGFILE_DATA_W   : register data width
//   REGFILE_NUM_REGS : number of architectural registers
//   reg_addr_t       : register address type
//   reg_data_t       : register data type
//   DROP_CNT_W       : width of the suppressed-r0-write counter
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REGFILE_ADDR_W   = 4;
    localparam int REGFILE_DATA_W   = 16;
    localparam int REGFILE_NUM_REGS = 16;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The search starts at
// ptr and wraps modulo NUM_REQ; the first requesting index wins. When a grant
// is issued, the pointer moves to one past the winner. Otherwise it holds.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (ptr -> 0)
//   req    : per-requester request
//   enable : grant permitted this cycle
//   grant  : one-hot-or-zero grant (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;

    // NOTE: every combinational output is given a default before the search
    // loop, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        if (enable && found) begin
            grant[win] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// ---------------------------------------------------------------------------
// regfile_wr_sched
// Write-port scheduler for the register file. NUM_REQ requesters compete
// round-robin for the single write port. The winner's address and data are
// captured, and one cycle later they are driven to the bank as a one-hot
// write enable plus data. When PROTECT_R0 is set, writes to r0 are accepted
// but suppressed and counted in a saturating counter.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req_valid : per-requester write request
//   req_addr  : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  : packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready : one-hot-or-zero acceptance (combinational)
//   stall     : bank cannot take a new write; blocks acceptance only
//   wr_en     : one-hot-or-zero register write enables
//   wr_data   : data for the enabled register
//   drop_cnt  : saturating count of suppressed r0 writes
// ---------------------------------------------------------------------------
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = REGFILE_DATA_W,
    parameter int ADDR_W     = REGFILE_ADDR_W,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    stall,
    output logic [2**ADDR_W-1:0]    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               issue_vld;
    logic [ADDR_W-1:0]  issue_addr;
    logic [DATA_W-1:0]  issue_data;
    logic               r0_issue;

    // No acceptance while reset is held, so req_ready reads zero under rst.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (~stall & ~rst),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // The grant is one-hot, so an OR of masked fields selects the winner.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Single-entry issue stage. Address and data hold when nothing is
    // accepted, which keeps wr_data at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_vld  <= 1'b0;
            issue_addr <= '0;
            issue_data <= '0;
        end else begin
            issue_vld <= accept;
            if (accept) begin
                issue_addr <= sel_addr;
                issue_data <= sel_data;
            end
        end
    end

    assign r0_issue = PROTECT_R0 && issue_vld && (issue_addr == '0);

    // wr_en is decoded from the issue flops, so an asynchronous reset
    // clears it right away without waiting for a clock edge.
    always_comb begin
        wr_en = '0;
        if (issue_vld && !r0_issue) begin
            wr_en[issue_addr] = 1'b1;
        end
    end

    assign wr_data = issue_data;

    // The suppressed write is counted at the end of its issue cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (r0_issue && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_sched
// Directed bench for regfile_wr_sched (NUM_REQ=4, DATA_W=16, ADDR_W=4,
// PROTECT_R0=1). Inputs change on the falling edge. Each step first checks
// the outputs of the write issued by the previous step (popped from the
// scoreboard). It then checks req_ready and pushes the write it expects to
// see issued in the following cycle.
// ---------------------------------------------------------------------------
module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        stall;
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic [7:0]  drop_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] en;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] hold;

    always #5 clk = ~clk;

    regfile_wr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall     (stall),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected end before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*16 +: 16] = d;
    endtask

    // Compare the current issue-stage outputs against the oldest entry.
    task automatic check_out(input string tag);
        exp_t e;
        e.en   = 16'h0;
        e.data = hold;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, ".wr_en"}, {16'h0, wr_en}, {16'h0, e.en});
        check({tag, ".wr_data"}, {16'h0, wr_data}, {16'h0, e.data});
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input logic [3:0] exp_ready, input string tag);
        exp_t        e;
        logic [3:0]  a;
        #1;
        check_out(tag);
        check({tag, ".req_ready"}, {28'h0, req_ready}, {28'h0, exp_ready});
        e.en   = 16'h0;
        e.data = hold;
        for (int i = 0; i < 4; i++) begin
            if (exp_ready[i]) begin
                a      = req_addr[i*4 +: 4];
                e.data = req_data[i*16 +: 16];
                if (a != 4'd0) e.en = 16'h1 << a;
            end
        end
        hold = e.data;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sb.delete();
        hold = 16'h0;
    endtask

    initial begin
        hold      = 16'h0;
        rst       = 1'b1;
        stall     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 16'h4321;
        req_data  = 64'h1111_2222_3333_4444;

        // Reset held with every requester valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.wr_en", {16'h0, wr_en}, 32'h0);
        check("reset.req_ready", {28'h0, req_ready}, 32'h0);
        check("reset.drop_cnt", {24'h0, drop_cnt}, 32'h0);
        check("reset.wr_data", {16'h0, wr_data}, 32'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;
        step(4'b0000, "idle0");

        // Single write: addr 5, data 0xBEEF, then one idle cycle.
        req_valid = 4'b0001;
        set_req(0, 4'd5, 16'hBEEF);
        step(4'b0001, "single");
        req_valid = 4'b0000;
        step(4'b0000, "single.issue");
        step(4'b0000, "single.after");

        // Round-robin from ptr 0 with all four held valid.
        pulse_reset();
        set_req(0, 4'd1, 16'hA000);
        set_req(1, 4'd2, 16'hA001);
        set_req(2, 4'd3, 16'hA002);
        set_req(3, 4'd4, 16'hA003);
        req_valid = 4'b1111;
        step(4'b0001, "rr0");
        step(4'b0010, "rr1");
        step(4'b0100, "rr2");
        step(4'b1000, "rr3");
        step(4'b0001, "rr4");

        // Stall: accept requester 1, then stall for two cycles.
        set_req(0, 4'd9,  16'hC000);
        set_req(1, 4'd6,  16'hC001);
        set_req(2, 4'd3,  16'hC002);
        set_req(3, 4'd12, 16'hC003);
        req_valid = 4'b0010;
        step(4'b0010, "stall.acc");
        req_valid = 4'b1111;
        stall     = 1'b1;
        step(4'b0000, "stall.c1");
        step(4'b0000, "stall.c2");
        stall = 1'b0;
        step(4'b0100, "stall.resume");

        // Wrap-around from ptr 3 to requester 0, then requester 1.
        req_valid = 4'b0011;
        step(4'b0001, "wrap0");
        step(4'b0010, "wrap1");
        req_valid = 4'b0000;
        step(4'b0000, "wrap.idle");

        // r0 protection: 10 writes, then count; then up to 300 total.
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            set_req(0, 4'd0, 16'(i));
            step(4'b0001, "r0a");
        end
        req_valid = 4'b0000;
        step(4'b0000, "r0a.idle0");
        step(4'b0000, "r0a.idle1");
        check("r0.drop_cnt10", {24'h0, drop_cnt}, 32'd10);
        req_valid = 4'b0001;
        for (int i = 10; i < 300; i++) begin
            set_req(0, 4'd0, 16'(i));
            step(4'b0001, "r0b");
        end
        req_valid = 4'b0000;
        step(4'b0000, "r0b.idle0");
        step(4'b0000, "r0b.idle1");
        check("r0.drop_cnt_sat", {24'h0, drop_cnt}, 32'd255);

        // Asynchronous reset while wr_en = 0x0100.
        req_valid = 4'b0001;
        set_req(0, 4'd8, 16'h5A5A);
        step(4'b0001, "async.acc");
        req_valid = 4'b0000;
        #1;
        check_out("async.pre");
        #2;
        rst = 1'b1;
        #1;
        check("async.wr_en", {16'h0, wr_en}, 32'h0);
        check("async.wr_data", {16'h0, wr_data}, 32'h0);
        check("async.ptr", 32'(dut.u_arb.ptr), 32'h0);
        check("async.drop_cnt", {24'h0, drop_cnt}, 32'h0);
        check("async.req_ready", {28'h0, req_ready}, 32'h0);
        sb.delete();
        hold = 16'h0;
        @(negedge clk);
        rst = 1'b0;

        // After reset the search starts at requester 0 again.
        req_valid = 4'b0011;
        set_req(0, 4'd7, 16'hD000);
        set_req(1, 4'd2, 16'hD001);
        step(4'b0001, "post.rst0");
        req_valid = 4'b0000;
        step(4'b0000, "post.rst.issue");
        step(4'b0000, "post.rst.idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
